// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup and EXE-side training bundle for the branch target buffer.
// The master drives the PC and training inputs. The slave (the BTB) returns the prediction.
interface branch_target_buffer_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] pc_IF;
  logic            stall;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            pred_hit;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;

  modport master (
    output pc_IF, stall, upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_hit, pred_taken, pred_target
  );

  modport slave (
    input  pc_IF, stall, upd_valid, upd_pc, upd_taken, upd_target,
    output pred_hit, pred_taken, pred_target
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
// Lookup is combinational from stored state. Training is applied on the next rising edge.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int PC_W    = 32
) (
  input logic                    clk,
  input logic                    rst,
  branch_target_buffer_if.slave  bus
);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic             valid_all  [ENTRIES];
  logic [TAG_W-1:0] tag_all    [ENTRIES];
  logic [PC_W-1:0]  target_all [ENTRIES];
  logic [1:0]       cnt_all    [ENTRIES];

  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_en;
  logic             unused_pc_bits;

  assign look_idx = bus.pc_IF[IDX_W+1:2];
  assign look_tag = bus.pc_IF[PC_W-1:IDX_W+2];
  assign upd_idx  = bus.upd_pc[IDX_W+1:2];
  assign upd_tag  = bus.upd_pc[PC_W-1:IDX_W+2];
  assign upd_en   = bus.upd_valid && !bus.stall;

  // The byte offset never takes part in indexing or tag matching.
  assign unused_pc_bits = ^{bus.pc_IF[1:0], bus.upd_pc[1:0]};

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic             valid_reg;
      logic [TAG_W-1:0] tag_reg;
      logic [PC_W-1:0]  target_reg;
      logic [1:0]       cnt_reg;
      logic             sel;
      logic             hit;

      assign sel = upd_en && (upd_idx == IDX_W'(gi));
      assign hit = valid_reg && (tag_reg == upd_tag);

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg  <= 1'b0;
          tag_reg    <= '0;
          target_reg <= '0;
          cnt_reg    <= 2'b01;
        end else if (sel) begin
          if (hit) begin
            if (bus.upd_taken) begin
              cnt_reg    <= (cnt_reg == 2'b11) ? 2'b11 : cnt_reg + 2'd1;
              target_reg <= bus.upd_target;
            end else begin
              cnt_reg <= (cnt_reg == 2'b00) ? 2'b00 : cnt_reg - 2'd1;
            end
          end else if (bus.upd_taken) begin
            // A taken miss evicts whatever occupied the slot. A not-taken miss leaves it alone.
            valid_reg  <= 1'b1;
            tag_reg    <= upd_tag;
            target_reg <= bus.upd_target;
            cnt_reg    <= 2'b10;
          end
        end
      end

      assign valid_all[gi]  = valid_reg;
      assign tag_all[gi]    = tag_reg;
      assign target_all[gi] = target_reg;
      assign cnt_all[gi]    = cnt_reg;
    end
  endgenerate

  logic look_hit;

  always_comb begin
    look_hit        = valid_all[look_idx] && (tag_all[look_idx] == look_tag);
    bus.pred_hit    = look_hit;
    bus.pred_taken  = look_hit && cnt_all[look_idx][1];
    bus.pred_target = look_hit ? target_all[look_idx] : '0;
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer. Each step queues its expected prediction,
// and the prediction is checked mid-cycle, before the edge that applies that step's update.
module tb_branch_target_buffer;
  logic clk;
  logic rst;

  branch_target_buffer_if #(.PC_W(32)) bus ();

  branch_target_buffer #(.ENTRIES(16), .IDX_W(4), .PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t sb[$];
  int n_compared = 0;
  int n_failed   = 0;

  task automatic step(input string tag, input logic r, input logic [31:0] pc,
                      input logic st, input logic uv, input logic [31:0] up,
                      input logic ut, input logic [31:0] utg,
                      input logic chk, input logic eh, input logic et,
                      input logic [31:0] etg);
    @(posedge clk);
    #1;
    rst            = r;
    bus.pc_IF      = pc;
    bus.stall      = st;
    bus.upd_valid  = uv;
    bus.upd_pc     = up;
    bus.upd_taken  = ut;
    bus.upd_target = utg;
    if (chk) sb.push_back('{tag, eh, et, etg});
    @(negedge clk);
    if (chk) begin
      exp_t e;
      e = sb.pop_front();
      n_compared++;
      assert (bus.pred_hit === e.hit) else begin
        n_failed++;
        $error("FAIL %s pred_hit got %b want %b", e.tag, bus.pred_hit, e.hit);
      end
      n_compared++;
      assert (bus.pred_taken === e.taken) else begin
        n_failed++;
        $error("FAIL %s pred_taken got %b want %b", e.tag, bus.pred_taken, e.taken);
      end
      n_compared++;
      assert (bus.pred_target === e.target) else begin
        n_failed++;
        $error("FAIL %s pred_target got %h want %h", e.tag, bus.pred_target, e.target);
      end
      $display("step %-14s pc=%h hit=%b taken=%b target=%h", e.tag, pc,
               bus.pred_hit, bus.pred_taken, bus.pred_target);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.pc_IF = '0; bus.stall = 1'b0; bus.upd_valid = 1'b0;
    bus.upd_pc = '0; bus.upd_taken = 1'b0; bus.upd_target = '0;

    //    tag              rst  pc     stl uv up     ut  utg     chk hit tkn target
    step("rst0",           1, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0);
    step("rst1",           1, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0);
    step("reset_miss",     0, 32'h100, 0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 32'h0);
    // first allocation: lookup in the same cycle still sees the empty slot
    step("alloc_pre",      0, 32'h100, 0, 1, 32'h100, 1, 32'h80,  1, 0, 0, 32'h0);
    step("alloc_hit",      0, 32'h101, 0, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h80);
    step("t1",             0, 32'h100, 0, 1, 32'h100, 1, 32'h80,  1, 1, 1, 32'h80);
    step("t2",             0, 32'h100, 0, 1, 32'h100, 1, 32'h80,  1, 1, 1, 32'h80);
    step("t3_newtgt",      0, 32'h100, 0, 1, 32'h102, 1, 32'h88,  1, 1, 1, 32'h80);
    step("n1",             0, 32'h100, 0, 1, 32'h100, 0, 32'hfff0,1, 1, 1, 32'h88);
    step("n2",             0, 32'h100, 0, 1, 32'h100, 0, 32'hfff0,1, 1, 1, 32'h88);
    step("n3",             0, 32'h100, 0, 1, 32'h100, 0, 32'hfff0,1, 1, 0, 32'h88);
    step("n3_after",       0, 32'h100, 0, 1, 32'h100, 0, 32'hfff0,1, 1, 0, 32'h88);
    step("cnt00",          0, 32'h100, 0, 0, 32'h0,   0, 32'h0,   1, 1, 0, 32'h88);
    // alias at idx 0: 0x140 evicts 0x100
    step("alias_upd",      0, 32'h100, 0, 1, 32'h140, 1, 32'h200, 1, 1, 0, 32'h88);
    step("alias_old_miss", 0, 32'h100, 0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 32'h0);
    step("alias_new_hit",  0, 32'h140, 0, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h200);
    step("alias_nt_miss",  0, 32'h180, 0, 1, 32'h180, 0, 32'h300, 1, 0, 0, 32'h0);
    step("alias_kept",     0, 32'h140, 0, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h200);
    step("alias_no_alloc", 0, 32'h180, 0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 32'h0);
    // stall blocks both allocation and counter decrement
    step("stall_alloc",    0, 32'h20,  1, 1, 32'h20,  1, 32'h40,  1, 0, 0, 32'h0);
    step("stall_dec",      0, 32'h140, 1, 1, 32'h140, 0, 32'h0,   1, 1, 1, 32'h200);
    step("stall_rel_miss", 0, 32'h20,  0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 32'h0);
    step("stall_cnt_kept", 0, 32'h140, 0, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h200);
    // retrain 0x100 to cnt 01, then same-cycle lookup and not-taken update
    step("retrain",        0, 32'h140, 0, 1, 32'h100, 1, 32'h80,  1, 1, 1, 32'h200);
    step("to_01",          0, 32'h100, 0, 1, 32'h100, 0, 32'h0,   1, 1, 1, 32'h80);
    step("same_cycle",     0, 32'h100, 0, 1, 32'h100, 0, 32'h0,   1, 1, 0, 32'h80);
    step("cnt_now_00",     0, 32'h100, 0, 1, 32'h100, 1, 32'h90,  1, 1, 0, 32'h80);
    step("inc_to_01",      0, 32'h100, 0, 0, 32'h0,   0, 32'h0,   1, 1, 0, 32'h90);
    // reset wins over a simultaneous update and discards training
    step("rst_with_upd",   1, 32'h100, 0, 1, 32'h20,  1, 32'h40,  0, 0, 0, 32'h0);
    step("post_rst_100",   0, 32'h100, 0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 32'h0);
    step("post_rst_20",    0, 32'h20,  0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 32'h0);
    step("post_rst_140",   0, 32'h140, 0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end
endmodule
